// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared frame width, FSM state encodings and preamble pattern for frame_tx/frame_rx
package frame_tx_pkg;
    localparam int FRAME_SIZE = 16;
    localparam int BIT_CNT_W = 5;
    localparam logic [3:0] TX_PREAMBLE = 4'b0101;
    typedef enum logic [2:0] {
        TX_ST_IDLE     = 3'd0,
        TX_ST_PREAMBLE = 3'd1,
        TX_ST_START    = 3'd2,
        TX_ST_DATA     = 3'd3,
        TX_ST_STOP     = 3'd4
    } tx_state_t;
endpackage

// File: rtl/frame_tx_if.sv
// frame_tx_if: frame handshake and serial line bundle between a frame source and frame_tx
interface frame_tx_if;
    import frame_tx_pkg::*;
    logic [FRAME_SIZE-1:0] frame_in;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  tx_line;
    logic                  busy;
    logic                  tx_done;
    modport master (output frame_in, frame_valid, input frame_ready, tx_line, busy, tx_done);
    modport slave (input frame_in, frame_valid, output frame_ready, tx_line, busy, tx_done);
endinterface

// File: rtl/frame_tx_bit_timer.sv
// frame_tx_bit_timer: CLKS_PER_BIT down counter, ticks on zero, reloads on tick or load
module frame_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_tick
);
    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
    logic [15:0] r_count;
    // count down one bit period, restarting on a state entry or after each tick
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_count <= RELOAD;
        else r_count <= (i_load || r_count == 16'd0) ? RELOAD : r_count - 16'd1;
    end
    assign o_tick = (r_count == 16'd0);
endmodule

// File: rtl/frame_tx.sv
// frame_tx: serializes one codeword per handshake as start bit, LSB-first data, stop bits (optional preamble: FRAME_TX_PREAMBLE_EN)
module frame_tx
    import frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input logic       i_clk,
    input logic       i_rst_n,
    frame_tx_if.slave bus
);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_SIZE - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
    tx_state_t             r_state, w_state_nxt;
    logic [FRAME_SIZE-1:0] r_shift, w_shift_nxt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_line, w_line_nxt;
    logic                  r_busy, r_ready, r_done, w_done_nxt;
    logic                  w_load, w_tick;
`ifdef FRAME_TX_PREAMBLE_EN
    logic [1:0]            w_pre_idx;
    assign w_pre_idx = r_bit_cnt[1:0] + 2'd1;
`endif
    frame_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .o_tick  (w_tick)
    );
    // next state: every transition reloads the timer and clears the bit counter
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_line_nxt    = r_line;
        w_done_nxt    = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            TX_ST_IDLE: if (bus.frame_valid) begin
                w_shift_nxt   = bus.frame_in;
                w_bit_cnt_nxt = '0;
                w_load        = 1'b1;
`ifdef FRAME_TX_PREAMBLE_EN
                w_state_nxt   = TX_ST_PREAMBLE;
                w_line_nxt    = TX_PREAMBLE[0];
`else
                w_state_nxt   = TX_ST_START;
                w_line_nxt    = 1'b1;
`endif
            end
`ifdef FRAME_TX_PREAMBLE_EN
            TX_ST_PREAMBLE: if (w_tick) begin
                if (r_bit_cnt == BIT_CNT_W'(3)) begin
                    w_state_nxt   = TX_ST_START;
                    w_bit_cnt_nxt = '0;
                    w_line_nxt    = 1'b1;
                    w_load        = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_line_nxt    = TX_PREAMBLE[w_pre_idx];
                end
            end
`endif
            TX_ST_START: if (w_tick) begin
                w_state_nxt   = TX_ST_DATA;
                w_bit_cnt_nxt = '0;
                w_line_nxt    = r_shift[0];
                w_load        = 1'b1;
            end
            TX_ST_DATA: if (w_tick) begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt   = TX_ST_STOP;
                    w_bit_cnt_nxt = '0;
                    w_line_nxt    = 1'b0;
                    w_load        = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_shift_nxt   = r_shift >> 1;
                    w_line_nxt    = r_shift[1];
                end
            end
            TX_ST_STOP: if (w_tick) begin
                if (r_bit_cnt == LAST_STOP) begin
                    w_state_nxt   = TX_ST_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                    w_done_nxt    = 1'b1;
                    w_load        = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = TX_ST_IDLE;
                w_line_nxt  = 1'b0;
            end
        endcase
    end
    // state and registered outputs; ready/busy follow the state being entered
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= TX_ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_line    <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_line    <= w_line_nxt;
            r_busy    <= (w_state_nxt != TX_ST_IDLE);
            r_ready   <= (w_state_nxt == TX_ST_IDLE);
            r_done    <= w_done_nxt;
        end
    end
    assign bus.tx_line     = r_line;
    assign bus.busy        = r_busy;
    assign bus.frame_ready = r_ready;
    assign bus.tx_done     = r_done;
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: scoreboarded line capture of frame_tx, table-driven frames plus corner sequences
module tb_frame_tx;
    import frame_tx_pkg::*;
`ifdef FRAME_TX_PREAMBLE_EN
    localparam int PRE_BITS = 4;
`else
    localparam int PRE_BITS = 0;
`endif
    typedef struct { logic [15:0] frame; int cpb; int stop; } exp_t;
    typedef struct { logic [15:0] frame; int pc; } vec_t;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n, sel, v;
    logic [15:0] fin;
    int          cyc = 0, pass_cnt = 0, total_cnt = 0;
    int          hs_cyc, start_cyc, done_cyc, last_ones, frames_done = 0;
    int          done_hist[$];
    exp_t        sb[$];
    bit          cap[$];
    vec_t        tab[5] = '{'{16'h0000, 0}, '{16'hFFFF, 16}, '{16'h8001, 2},
                            '{16'h1234, 5}, '{16'h3C5A, 8}};

    frame_tx_if if0();
    frame_tx_if if1();
    assign if0.frame_in    = fin;
    assign if0.frame_valid = v & ~sel;
    assign if1.frame_in    = fin;
    assign if1.frame_valid = v & sel;

    frame_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (.i_clk(clk), .i_rst_n(rst0_n), .bus(if0));
    frame_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u1 (.i_clk(clk), .i_rst_n(rst1_n), .bus(if1));

    logic m_busy, m_line, m_done, m_ready;
    assign m_busy  = sel ? if1.busy : if0.busy;
    assign m_line  = sel ? if1.tx_line : if0.tx_line;
    assign m_done  = sel ? if1.tx_done : if0.tx_done;
    assign m_ready = sel ? if1.frame_ready : if0.frame_ready;

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit exp_bit(input logic [15:0] f, input int cpb, input int i);
        int b = i / cpb;
        if (b < PRE_BITS) return (b % 2) == 0;
        b -= PRE_BITS;
        if (b == 0) return 1'b1;
        if (b <= 16) return f[b-1];
        return 1'b0;
    endfunction

    task automatic score(input exp_t e);
        int len = (PRE_BITS + 1 + 16 + e.stop) * e.cpb;
        int mism = 0;
        last_ones = 0;
        check($sformatf("len_%h", e.frame), cap.size(), len);
        foreach (cap[i]) begin
            last_ones += int'(cap[i]);
            if (i < len && cap[i] != exp_bit(e.frame, e.cpb, i)) mism++;
        end
        check($sformatf("bits_%h_mismatches", e.frame), mism, 0);
    endtask

    // monitor: capture the line while busy, score on tx_done, drop on abort
    initial forever begin
        @(negedge clk);
        if (m_busy) begin
            if (cap.size() == 0) start_cyc = cyc;
            cap.push_back(m_line);
        end else if (m_done) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) score(sb.pop_front());
            done_cyc = cyc;
            done_hist.push_back(cyc);
            frames_done++;
            cap.delete();
        end else begin
            cap.delete();
        end
    end

    task automatic send(input logic [15:0] f, input int cpb, input int stop);
        int n = 0;
        @(negedge clk);
        v = 1'b1;
        fin = f;
        while (!m_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", m_ready, 1);
        hs_cyc = cyc;
        sb.push_back('{f, cpb, stop});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        v = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (frames_done < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_in_time", frames_done >= target, 1);
    endtask

    initial begin
        int hs2, tgt, n, fd;
        v = 1'b0; fin = '0; sel = 1'b0; rst0_n = 1'b0; rst1_n = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        @(negedge clk);
        check("rst_line", m_line, 0);
        check("rst_busy", m_busy, 0);
        check("rst_done", m_done, 0);
        check("rst_ready", m_ready, 1);

        // 1: single frame timing
        send(16'hA5C3, 4, 1);
        idle();
        wait_frame(1);
        check("t1_start_cycle", start_cyc - hs_cyc, 1);
        check("t1_done_cycle", done_cyc - hs_cyc, 73 + 4 * PRE_BITS);
        check("t1_ones", last_ones, 36 + 4 * (PRE_BITS / 2));

        // table of frames
        foreach (tab[i]) begin
            fd = frames_done;
            send(tab[i].frame, 4, 1);
            idle();
            wait_frame(fd + 1);
            check($sformatf("tab%0d_ones", i), last_ones, 4 * (1 + tab[i].pc) + 4 * (PRE_BITS / 2));
        end

        // 2: held valid, second frame taken in the tx_done cycle
        fd = frames_done;
        send(16'h0001, 4, 1);
        send(16'hFFFF, 4, 1);
        hs2 = hs_cyc;
        idle();
        wait_frame(fd + 2);
        check("t2_hs_in_done_cycle", hs2, done_hist[done_hist.size() - 2]);
        check("t2_idle_gap", start_cyc - done_hist[done_hist.size() - 2], 1);

        // 3: mid-frame valid and frame_in change are ignored
        fd = frames_done;
        send(16'h3C5A, 4, 1);
        idle();
        repeat (10) @(negedge clk);
        fin = 16'hFFFF;
        v = 1'b1;
        check("t3_ready_low", m_ready, 0);
        @(negedge clk);
        v = 1'b0;
        wait_frame(fd + 1);
        check("t3_single_frame", frames_done, fd + 1);

        // 4: reset during data bit 7
        fd = frames_done;
        send(16'h96E1, 4, 1);
        idle();
        tgt = hs_cyc + 34 + 4 * PRE_BITS;
        n = 0;
        while (cyc < tgt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_bit7_line", m_line, 1);
        rst0_n = 1'b0;
        @(negedge clk);
        void'(sb.pop_front());
        rst0_n = 1'b1;
        check("t4_line", m_line, 0);
        check("t4_busy", m_busy, 0);
        check("t4_ready", m_ready, 1);
        check("t4_done", m_done, 0);
        repeat (10) @(negedge clk);
        check("t4_no_done", frames_done, fd);
        send(16'h5A5A, 4, 1);
        idle();
        wait_frame(fd + 1);
        check("t4_after_done_cycle", done_cyc - hs_cyc, 73 + 4 * PRE_BITS);

        // 5: CLKS_PER_BIT=1, STOP_BITS=2
        sel = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", m_ready, 1);
        fd = frames_done;
        send(16'h8000, 1, 2);
        idle();
        wait_frame(fd + 1);
        check("t5_done_cycle", done_cyc - hs_cyc, 20 + PRE_BITS);
        check("t5_ones", last_ones, 2 + PRE_BITS / 2);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
